flag_ctrl: RTL

- Sequencing controller for the 8-bit Flag register. The register loads `Flagin` on every `Clk` edge and has no enable, so this block must always present the correct next value.
- Merges three update sources into one next-value for the register:
  - masked ALU flag writes;
  - explicit PSW loads;
  - interrupt save/restore through a small LIFO flag stack.
- Sits between the ALU/decoder/interrupt unit and the Flag register. It consumes `Flagout` and produces `Flagin`.

---
 rtl/flag_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/flag_ctrl.sv
// flag_ctrl: computes the next Flag register value from ALU merges, PSW loads and a LIFO save/restore stack.
// Build macro FLAG_CTRL_STICKY_EN makes the STICKY_MASK bits set-only on ALU writes.
module flag_ctrl #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter int               PTR_W       = 3,
  parameter logic [WIDTH-1:0] STICKY_MASK = 8'h80
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Flagout,
  input  logic             Alu_we,
  input  logic [WIDTH-1:0] Alu_flags,
  input  logic [WIDTH-1:0] Alu_mask,
  input  logic             Ld_we,
  input  logic [WIDTH-1:0] Ld_data,
  input  logic             Push_req,
  input  logic             Pop_req,
  output logic [WIDTH-1:0] Flagin,
  output logic             Busy,
  output logic [PTR_W-1:0] Depth,
  output logic             Ovf_err,
  output logic             Unf_err
);

  localparam int               ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_MAX = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

`ifdef FLAG_CTRL_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif
  localparam logic [WIDTH-1:0] STICKY_BITS = STICKY_MASK & {WIDTH{STICKY_ON}};

  typedef enum logic [1:0] {IDLE, POP_RD, POP_WR} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  depth_q, depth_d;
  logic              busy_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_we;
  logic [WIDTH-1:0]  pop_data_q;
  logic [WIDTH-1:0]  stack_mem [DEPTH];
  logic [ADDR_W-1:0] stk_addr;
  logic [WIDTH-1:0]  alu_merge;
  logic [WIDTH-1:0]  flagin_d;
  logic              is_full, is_empty;

  assign is_full  = (depth_q == DEPTH_MAX);
  assign is_empty = (depth_q == '0);
  // Push writes at the old depth; POP_RD reads at the already-decremented depth.
  assign stk_addr = depth_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    push_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (Pop_req) begin
          if (!is_empty) begin
            depth_d = depth_q - PTR_ONE;
            state_d = POP_RD;
          end else begin
            unf_d = 1'b1;
          end
        end else if (Push_req) begin
          if (!is_full) begin
            push_we = 1'b1;
            depth_d = depth_q + PTR_ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      POP_RD:  state_d = POP_WR;
      POP_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      busy_q  <= (state_d != IDLE);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_we) begin
      stack_mem[stk_addr] <= Flagout;
    end
    if (state_q == POP_RD) begin
      pop_data_q <= stack_mem[stk_addr];
    end
  end

  // Sticky bits can only be set by the ALU; all others take the plain masked merge.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
    if (STICKY_BITS[gi]) begin : g_sticky
      assign alu_merge[gi] = Flagout[gi] | (Alu_flags[gi] & Alu_mask[gi]);
    end else begin : g_plain
      assign alu_merge[gi] = Alu_mask[gi] ? Alu_flags[gi] : Flagout[gi];
    end
  end

  always_comb begin
    flagin_d = Flagout;
    if (Reset) begin
      flagin_d = '0;
    end else if (state_q == POP_WR) begin
      flagin_d = pop_data_q;
    end else if (state_q == IDLE && Ld_we) begin
      flagin_d = Ld_data;
    end else if (state_q == IDLE && Alu_we) begin
      flagin_d = alu_merge;
    end
  end

  assign Flagin  = flagin_d;
  assign Busy    = busy_q;
  assign Depth   = depth_q;
  assign Ovf_err = ovf_q;
  assign Unf_err = unf_q;

endmodule
